// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scheduler.
package sobel_pkg;
  localparam int PIX_STRIDE = 4;
  localparam int WIN_TAPS   = 9;
  localparam int PIX_W      = 8;

  typedef logic [WIN_TAPS-1:0][PIX_W-1:0] win_t;

  typedef logic [2:0] sched_state_t;
  localparam sched_state_t S_IDLE     = 3'd0;
  localparam sched_state_t S_CHECK    = 3'd1;
  localparam sched_state_t S_FETCH    = 3'd2;
  localparam sched_state_t S_PRESENT  = 3'd3;
  localparam sched_state_t S_WAIT_RES = 3'd4;
  localparam sched_state_t S_WRITE    = 3'd5;
  localparam sched_state_t S_FINISH   = 3'd6;
endpackage

// File: rtl/sobel_addr_gen.sv
// Read/write address generator: the row base advances by W*4 per output row,
// so tap addresses need only shifts and adds.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              row_adv,
  input  logic              wr_adv,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  out_col,
  input  logic [1:0]        tap_row,
  input  logic [1:0]        tap_col,
  input  logic              sel_wr,
  output logic [ADDR_W-1:0] addr
);
  localparam int PW = 2 * DIM_W;

  logic [ADDR_W-1:0] row_base, wr_ptr, row_step, row_off;
  logic [PW-1:0]     w4, c4;

  assign w4       = PW'(width) << 2;
  assign row_step = ADDR_W'(w4);
  assign c4       = (PW'(out_col) + PW'(tap_col)) << 2;

  always_comb begin
    row_off = '0;
    case (tap_row)
      2'd1:    row_off = row_step;
      2'd2:    row_off = row_step << 1;
      default: row_off = '0;
    endcase
  end

  assign addr = sel_wr ? wr_ptr : (row_base + row_off + ADDR_W'(c4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      wr_ptr   <= '0;
    end else if (init) begin
      row_base <= img_base;
      wr_ptr   <= out_base;
    end else begin
      if (row_adv) row_base <= row_base + row_step;
      if (wr_adv)  wr_ptr   <= wr_ptr + ADDR_W'(PIX_STRIDE);
    end
  end
endmodule

// File: rtl/sobel_window_sched.sv
// Walks interior pixels, fetches 3x3 windows over one memory port, writes results.
// Define SOBEL_SCHED_PERF_EN to add perf_cycles/perf_stalls counters.
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     image_start_addr,
  input  logic [ADDR_W-1:0]     out_start_addr,
  input  logic [DIM_W-1:0]      image_width,
  input  logic [DIM_W-1:0]      image_height,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  input  logic                  mem_waitrequest,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_pixels,
  input  logic                  res_valid,
  input  logic [DATA_W-1:0]     res_data,
  output logic                  busy,
  output logic                  done
`ifdef SOBEL_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);
  sched_state_t state;

  logic [ADDR_W-1:0] img_base_q, out_base_q, gen_addr;
  logic [DIM_W-1:0]  width_q, height_q, out_row, out_col, col_nxt, row_nxt;
  logic [1:0]        tap_r, tap_c;
  logic [3:0]        tap_k;
  logic [WIN_TAPS-1:0][DATA_W-1:0] win;
  logic [DATA_W-1:0] res_q;
  logic              last_col, last_row, wr_acc;

  assign col_nxt  = out_col + DIM_W'(1);
  assign row_nxt  = out_row + DIM_W'(1);
  assign last_col = (col_nxt == width_q - DIM_W'(2));
  assign last_row = (row_nxt == height_q - DIM_W'(2));
  assign tap_k    = 4'(tap_r) * 4'd3 + 4'(tap_c);
  assign wr_acc   = (state == S_WRITE) && !mem_waitrequest;

  sobel_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .init     (state == S_CHECK),
    .row_adv  (wr_acc && last_col),
    .wr_adv   (wr_acc),
    .img_base (img_base_q),
    .out_base (out_base_q),
    .width    (width_q),
    .out_col  (out_col),
    .tap_row  (tap_r),
    .tap_col  (tap_c),
    .sel_wr   (state == S_WRITE),
    .addr     (gen_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      img_base_q <= '0;
      out_base_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      tap_r      <= '0;
      tap_c      <= '0;
      win        <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          img_base_q <= image_start_addr;
          out_base_q <= out_start_addr;
          width_q    <= image_width;
          height_q   <= image_height;
          state      <= S_CHECK;
        end
        S_CHECK: begin
          if (width_q < DIM_W'(3) || height_q < DIM_W'(3)) begin
            state <= S_FINISH;
          end else begin
            out_row <= '0;
            out_col <= '0;
            tap_r   <= '0;
            tap_c   <= '0;
            state   <= S_FETCH;
          end
        end
        // Column-major fetch; tap_c starts at 2 for the single-column refill.
        S_FETCH: if (!mem_waitrequest) begin
          win[tap_k] <= mem_readdata[DATA_W-1:0];
          if (tap_r == 2'd2) begin
            tap_r <= '0;
            if (tap_c == 2'd2) state <= S_PRESENT;
            else               tap_c <= tap_c + 2'd1;
          end else begin
            tap_r <= tap_r + 2'd1;
          end
        end
        S_PRESENT: if (win_ready) state <= S_WAIT_RES;
        S_WAIT_RES: if (res_valid) begin
          res_q <= res_data;
          state <= S_WRITE;
        end
        S_WRITE: if (!mem_waitrequest) begin
          tap_r <= '0;
          if (last_col) begin
            out_col <= '0;
            out_row <= row_nxt;
            tap_c   <= '0;
            state   <= last_row ? S_FINISH : S_FETCH;
          end else begin
            out_col <= col_nxt;
            tap_c   <= 2'd2;
            for (int r = 0; r < 3; r++) begin
              win[r*3]   <= win[r*3+1];
              win[r*3+1] <= win[r*3+2];
            end
            state <= S_FETCH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign mem_read      = (state == S_FETCH);
  assign mem_write     = (state == S_WRITE);
  assign mem_address   = (mem_read || mem_write) ? gen_addr : '0;
  assign mem_writedata = mem_write ? {{(32-DATA_W){1'b0}}, res_q} : '0;
  assign win_valid     = (state == S_PRESENT);
  assign win_pixels    = win;
  assign busy          = (state != S_IDLE) && (state != S_FINISH);
  assign done          = (state == S_FINISH);

`ifdef SOBEL_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((mem_read || mem_write) && mem_waitrequest) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sobel_window_sched.sv
// Randomized bench for sobel_window_sched against a per-pixel image model.
module tb_sobel_window_sched;
  import sobel_pkg::*;

  logic        tb_clk = 0;
  logic        rst;
  logic        start;
  logic [31:0] image_start_addr, out_start_addr;
  logic [15:0] image_width, image_height;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic        win_valid, win_ready, res_valid, busy, done;
  logic [71:0] win_pixels;
  logic [7:0]  res_data;

  always #5 tb_clk = ~tb_clk;

  sobel_window_sched dut (
    .clk(tb_clk), .rst(rst), .start(start),
    .image_start_addr(image_start_addr), .out_start_addr(out_start_addr),
    .image_width(image_width), .image_height(image_height),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .win_valid(win_valid), .win_ready(win_ready), .win_pixels(win_pixels),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
  );

  int n_tests = 0, n_fail = 0;
  int stall_n = 0;
  bit stray_en = 0;
  logic [31:0] mem [0:4095];
  logic [31:0] rd_log[$], wr_a[$], wr_d[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stand-in datapath: position-sensitive hash of the window.
  function automatic logic [7:0] dp_f(input win_t w);
    logic [7:0] a;
    a = 8'h11;
    for (int k = 0; k < 9; k++) a = (a * 8'd3) + (w[k] ^ 8'(k));
    return a;
  endfunction

  // Memory slave: programmable stall per request, garbage data while stalled.
  initial begin
    int          st_cnt;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [1:0]  prev_req;
    st_cnt = 0; prev_stall = 0; prev_addr = 0; prev_req = 0;
    mem_waitrequest = 0; mem_readdata = 0;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        prev_stall = 0; st_cnt = 0; mem_waitrequest = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_addr", mem_address, prev_addr);
          chk("hold_req", {mem_read, mem_write}, prev_req);
        end
        prev_stall = 0;
        if (mem_read || mem_write) begin
          chk("rd_wr_excl", mem_read & mem_write, 0);
          if (st_cnt < stall_n) begin
            mem_waitrequest = 1; mem_readdata = $urandom; st_cnt++;
            prev_stall = 1; prev_addr = mem_address; prev_req = {mem_read, mem_write};
          end else begin
            mem_waitrequest = 0; st_cnt = 0;
            if (mem_read) begin
              mem_readdata = mem[mem_address[13:2]];
              rd_log.push_back(mem_address);
            end else begin
              wr_a.push_back(mem_address);
              wr_d.push_back(mem_writedata);
            end
          end
        end else begin
          mem_waitrequest = 1'($urandom_range(0, 1));
          mem_readdata = $urandom;
        end
      end
    end
  end

  // Datapath stand-in: random ready, result 1..3 cycles later, optional stray pulses.
  initial begin
    int          dp_cnt;
    logic [7:0]  dp_res;
    bit          prev_hold;
    logic [71:0] prev_win;
    dp_cnt = 0; dp_res = 0; prev_hold = 0; prev_win = 0;
    win_ready = 0; res_valid = 0; res_data = 0;
    forever begin
      @(negedge tb_clk);
      res_valid = 0;
      if (rst) begin
        dp_cnt = 0; prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("win_hold_v", win_valid, 1);
          chk("win_hold_px", win_pixels, prev_win);
        end
        if (dp_cnt > 0) begin
          dp_cnt--;
          if (dp_cnt == 0) begin res_valid = 1; res_data = dp_res; end
        end else if (stray_en && mem_read && $urandom_range(0, 2) == 0) begin
          res_valid = 1; res_data = 8'hEE;
        end
        win_ready = 1'($urandom_range(0, 1));
        prev_hold = win_valid && !win_ready;
        prev_win  = win_pixels;
        if (win_valid && win_ready) begin
          dp_res = dp_f(win_pixels);
          dp_cnt = $urandom_range(1, 3);
        end
      end
    end
  end

  task automatic fill_img(input int w, input int h, input logic [31:0] ib);
    for (int i = 0; i < w * h; i++) mem[(ib >> 2) + i] = $urandom;
  endtask

  task automatic run_job(input int w, input int h, input logic [31:0] ib, input logic [31:0] ob,
                         input int stalls, input bit stray, input bit dbl, input int exp_lat);
    int cyc;
    bit prev_busy;
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
    win_t wm;
    int n;
    stall_n = stalls; stray_en = stray;
    rd_log.delete(); wr_a.delete(); wr_d.delete();
    @(negedge tb_clk);
    image_start_addr = ib; out_start_addr = ob;
    image_width = 16'(w); image_height = 16'(h);
    start = 1;
    @(negedge tb_clk);
    start = 0; cyc = 1; prev_busy = 0;
    while (!done && cyc < 4000) begin
      prev_busy = busy;
      if (dbl && cyc == 10) begin
        start = 1; image_width = 16'd5; image_height = 16'd9;
        image_start_addr = 32'h40; out_start_addr = 32'h0;
      end else if (dbl && cyc == 11) begin
        start = 0; image_start_addr = ib; out_start_addr = ob;
        image_width = 16'(w); image_height = 16'(h);
      end
      @(negedge tb_clk);
      cyc++;
    end
    start = 0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("busy_before_done", prev_busy, 1);
    if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
    if (!done) begin
      rst = 1; @(negedge tb_clk); rst = 0;
    end
    @(negedge tb_clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy | mem_read | mem_write, 0);

    // Reference: every interior pixel in raster order, full window at row start.
    n = 0;
    if (w >= 3 && h >= 3) begin
      for (int row = 0; row < h - 2; row++)
        for (int col = 0; col < w - 2; col++) begin
          for (int c = (col == 0 ? 0 : 2); c < 3; c++)
            for (int r = 0; r < 3; r++)
              exp_rd.push_back(ib + 32'(4 * ((row + r) * w + col + c)));
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              wm[r*3+c] = mem[(ib >> 2) + (row + r) * w + col + c][7:0];
          exp_wa.push_back(ob + 32'(4 * n));
          exp_wd.push_back({24'h0, dp_f(wm)});
          n++;
        end
    end
    chk("rd_count", rd_log.size(), exp_rd.size());
    chk("wr_count", wr_a.size(), exp_wa.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk("rd_addr", rd_log[i], exp_rd[i]);
    for (int i = 0; i < exp_wa.size() && i < wr_a.size(); i++) begin
      chk("wr_addr", wr_a[i], exp_wa[i]);
      chk("wr_data", wr_d[i], exp_wd[i]);
    end
  endtask

  initial begin
    rst = 1; start = 0;
    image_start_addr = 0; out_start_addr = 0; image_width = 0; image_height = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    @(negedge tb_clk);
    chk("rst_ctl", {mem_read, mem_write, win_valid, busy, done}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_writedata, 0);
    chk("rst_win", win_pixels, 0);
    @(negedge tb_clk);
    rst = 0;

    // 3x3: single window, spot-check the column-major read order.
    fill_img(3, 3, 32'h100);
    run_job(3, 3, 32'h100, 32'h800, 0, 0, 0, 0);
    if (rd_log.size() == 9) begin
      chk("rd3_k1", rd_log[1], 32'h10C);
      chk("rd3_k3", rd_log[3], 32'h104);
      chk("rd3_k8", rd_log[8], 32'h120);
    end else chk("rd3_len", rd_log.size(), 9);
    if (wr_a.size() == 1) chk("wr3_addr", wr_a[0], 32'h800);
    else chk("wr3_len", wr_a.size(), 1);

    // 4x4 without and with 3-cycle stalls on the same image.
    fill_img(4, 4, 32'h100);
    run_job(4, 4, 32'h100, 32'h800, 0, 0, 0, 0);
    chk("rd4_total", rd_log.size(), 24);
    run_job(4, 4, 32'h100, 32'h800, 3, 0, 0, 0);

    // Degenerate sizes: no bus traffic, done two cycles after start.
    run_job(2, 5, 32'h100, 32'h800, 0, 0, 0, 2);
    run_job(5, 2, 32'h100, 32'h800, 0, 0, 0, 2);

    // Reset while fetching the second window, then a clean 3x3 run.
    begin
      int cyc;
      fill_img(4, 3, 32'h200);
      stall_n = 0; stray_en = 0;
      rd_log.delete(); wr_a.delete(); wr_d.delete();
      @(negedge tb_clk);
      image_start_addr = 32'h200; out_start_addr = 32'h900;
      image_width = 16'd4; image_height = 16'd3; start = 1;
      @(negedge tb_clk);
      start = 0; cyc = 0;
      while (!(wr_a.size() >= 1 && mem_read) && cyc < 2000) begin
        @(negedge tb_clk); cyc++;
      end
      chk("reach_fetch2", wr_a.size() >= 1 && mem_read, 1);
      #1 rst = 1;
      #1;
      chk("abort_ctl", {mem_read, mem_write, win_valid, busy, done}, 0);
      chk("abort_addr", mem_address, 0);
      chk("abort_win", win_pixels, 0);
      @(negedge tb_clk);
      rst = 0;
      @(negedge tb_clk);
      chk("abort_quiet", mem_read | mem_write | busy, 0);
    end
    fill_img(3, 3, 32'h300);
    run_job(3, 3, 32'h300, 32'hA00, 0, 0, 0, 0);

    // Second start while busy plus stray res_valid pulses during fetch.
    fill_img(5, 4, 32'h180);
    run_job(5, 4, 32'h180, 32'h880, 1, 1, 1, 0);

    for (int j = 0; j < 6; j++) begin
      int w, h;
      logic [31:0] ib, ob;
      w  = $urandom_range(3, 7);
      h  = $urandom_range(3, 6);
      ib = 32'($urandom_range(0, 1000)) << 2;
      ob = 32'($urandom_range(2048, 3000)) << 2;
      fill_img(w, h, ib);
      run_job(w, h, ib, ob, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
